// File: rtl/exp_lut_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : exp_lut_pipe_if
// Purpose : Bundles the streaming input, the result output and the two
//           table-SRAM read ports of exp_lut_pipe.
//   in_valid/in_ready/in_x       : FP32 operand stream into the unit
//   out_valid/out_ready/out_y    : FP32 result stream out of the unit
//   sram_hi_* / sram_lo_*        : read enable, index and returned word
//   slave  : view taken by the exp unit
//   master : view taken by the surrounding datapath / tables
// Revision: 1.0 - initial release
// ============================================================================
interface exp_lut_pipe_if #(
    parameter int E_BITS  = 4,
    parameter int HI_BITS = 11
);
    localparam int LO_BITS = 23 - HI_BITS;

    logic                        in_valid;
    logic                        in_ready;
    logic [31:0]                 in_x;
    logic                        out_valid;
    logic                        out_ready;
    logic [31:0]                 out_y;
    logic                        sram_hi_en;
    logic [E_BITS+HI_BITS:0]     sram_hi_idx;
    logic [31:0]                 sram_hi_data;
    logic                        sram_lo_en;
    logic [E_BITS+LO_BITS:0]     sram_lo_idx;
    logic [31:0]                 sram_lo_data;

    modport slave (
        input  in_valid, in_x, out_ready, sram_hi_data, sram_lo_data,
        output in_ready, out_valid, out_y,
               sram_hi_en, sram_hi_idx, sram_lo_en, sram_lo_idx
    );

    modport master (
        output in_valid, in_x, out_ready, sram_hi_data, sram_lo_data,
        input  in_ready, out_valid, out_y,
               sram_hi_en, sram_hi_idx, sram_lo_en, sram_lo_idx
    );
endinterface
`default_nettype wire

// File: rtl/exp_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module  : FP_MUL_FP32
// Purpose : FP32 multiplier, round-to-nearest-even, denormals flushed to
//           zero, overflow to infinity. Result is delayed by LAT cycles.
//   clk, rst : clock, synchronous active-high reset
//   inA, inB : FP32 operands;  out : FP32 product (LAT cycles later)
// Revision: 1.0 - initial release
// ============================================================================
module FP_MUL_FP32 #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic [31:0] out
);
    logic [7:0]  ea, eb;
    logic [22:0] ma, mb;
    logic        sgn, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [47:0] prod;
    logic        top;
    logic [22:0] mant;
    logic        guard, sticky;
    logic [23:0] mant_r;
    logic [9:0]  e_sum;
    logic [31:0] res;
    logic [31:0] res_q [LAT];
    logic [31:0] res_d [LAT];

    assign ea     = inA[30:23];
    assign eb     = inB[30:23];
    assign ma     = inA[22:0];
    assign mb     = inB[22:0];
    assign sgn    = inA[31] ^ inB[31];
    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);
    assign inf_a  = (ea == 8'hFF) && (ma == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (mb == 23'd0);
    assign nan_a  = (ea == 8'hFF) && (ma != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (mb != 23'd0);

    always_comb begin
        prod   = 48'({1'b1, ma}) * 48'({1'b1, mb});
        top    = prod[47];
        // Product of two [1,2) significands lies in [1,4); normalise by one bit when >= 2.
        mant   = top ? prod[46:24] : prod[45:23];
        guard  = top ? prod[23]    : prod[22];
        sticky = top ? (|prod[22:0]) : (|prod[21:0]);
        mant_r = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
        // A rounding carry leaves mant_r[22:0] at zero, so only the exponent moves.
        e_sum  = {2'b00, ea} + {2'b00, eb} + {9'd0, top} + {9'd0, mant_r[23]} - 10'd127;
        res    = {sgn, e_sum[7:0], mant_r[22:0]};
        if (nan_a || nan_b || ((inf_a || inf_b) && (zero_a || zero_b))) begin
            res = 32'h7FC00000;
        end else if (inf_a || inf_b) begin
            res = {sgn, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
            res = {sgn, 31'd0};
        end else if ($signed(e_sum) >= 10'sd255) begin
            res = {sgn, 8'hFF, 23'd0};
        end else if ($signed(e_sum) <= 10'sd0) begin
            res = {sgn, 31'd0};
        end
    end

    always_comb begin
        res_d[0] = res;
        for (int i = 1; i < LAT; i++) begin
            res_d[i] = res_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LAT; i++) begin
            res_q[i] <= rst ? 32'd0 : res_d[i];
        end
    end

    assign out = res_q[LAT-1];
endmodule

// ============================================================================
// Module  : exp_lut_pipe
// Purpose : Pipelined FP32 exp(x). Two table words indexed by
//           {exponent offset, mantissa part, sign} are multiplied; IEEE
//           special cases and out-of-range exponents are overridden. Results
//           queue in a credit-protected output FIFO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand stream, result stream and table SRAM ports
// Revision: 1.0 - initial release
// ============================================================================
module exp_lut_pipe #(
    parameter int E_MIN      = -7,
    parameter int E_MAX      = 6,
    parameter int E_BITS     = 4,
    parameter int HI_BITS    = 11,
    parameter int SRAM_LAT   = 1,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    exp_lut_pipe_if.slave  bus
);
    localparam int LO_BITS = 23 - HI_BITS;
    localparam int PIPE_D  = SRAM_LAT + MUL_LAT;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int SUM_W   = $clog2(FIFO_DEPTH + PIPE_D + 1) + 1;
    localparam logic [7:0] C_EXP_LO = 8'(127 + E_MIN);
    localparam logic [7:0] C_EXP_HI = 8'(127 + E_MAX);

    typedef enum logic [2:0] {
        CLS_NORM = 3'd0,
        CLS_ONE  = 3'd1,
        CLS_PINF = 3'd2,
        CLS_ZERO = 3'd3,
        CLS_QNAN = 3'd4
    } cls_e;

    logic [7:0]        x_exp;
    logic [22:0]       x_man;
    logic              x_sgn;
    logic [E_BITS-1:0] e_off;
    cls_e              x_cls;
    logic              accept;

    assign x_exp  = bus.in_x[30:23];
    assign x_man  = bus.in_x[22:0];
    assign x_sgn  = bus.in_x[31];
    assign e_off  = E_BITS'(x_exp - C_EXP_LO);
    assign accept = bus.in_valid & bus.in_ready;

    assign bus.sram_hi_en  = accept;
    assign bus.sram_lo_en  = accept;
    assign bus.sram_hi_idx = {e_off, x_man[22:LO_BITS], x_sgn};
    assign bus.sram_lo_idx = {e_off, x_man[LO_BITS-1:0], x_sgn};

    // NaN is tested before infinity; exp(+inf)=+inf, exp(-inf)=+0.
    always_comb begin
        x_cls = CLS_NORM;
        if (x_exp == 8'hFF) begin
            if (x_man != 23'd0) x_cls = CLS_QNAN;
            else                x_cls = x_sgn ? CLS_ZERO : CLS_PINF;
        end else if (x_exp >= C_EXP_HI) begin
            x_cls = x_sgn ? CLS_ZERO : CLS_PINF;
        end else if (x_exp < C_EXP_LO) begin
            x_cls = CLS_ONE;
        end
    end

    // Class/valid shift register, aligned with the SRAM + multiplier latency.
    logic [PIPE_D-1:0] vld_q, vld_d;
    cls_e              cls_q [PIPE_D];
    cls_e              cls_d [PIPE_D];
    logic [SUM_W-1:0]  inflight;

    always_comb begin
        vld_d    = {vld_q[PIPE_D-2:0], accept};
        cls_d[0] = x_cls;
        for (int i = 1; i < PIPE_D; i++) begin
            cls_d[i] = cls_q[i-1];
        end
        inflight = '0;
        for (int i = 0; i < PIPE_D; i++) begin
            inflight = inflight + SUM_W'(vld_q[i]);
        end
    end

    logic [31:0] mul_out;

    FP_MUL_FP32 #(.LAT(MUL_LAT)) u_mul (
        .clk (clk),
        .rst (rst),
        .inA (bus.sram_hi_data),
        .inB (bus.sram_lo_data),
        .out (mul_out)
    );

    logic        push, pop;
    logic [31:0] wdata;

    assign push = vld_q[PIPE_D-1];

    always_comb begin
        case (cls_q[PIPE_D-1])
            CLS_QNAN: wdata = 32'h7FC00000;
            CLS_PINF: wdata = 32'h7F800000;
            CLS_ZERO: wdata = 32'h00000000;
            CLS_ONE:  wdata = 32'h3F800000;
            default:  wdata = mul_out;
        endcase
    end

    // Output FIFO
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [31:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign bus.out_valid = !rst && (count_q != '0);
    assign bus.out_y     = mem_q[rd_ptr_q];
    assign pop           = bus.out_valid & bus.out_ready;

    // Credits: every in-flight operation already owns a FIFO slot.
    assign bus.in_ready  = !rst && ((SUM_W'(count_q) + inflight) < SUM_W'(FIFO_DEPTH));

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        cls_q <= cls_d;
        mem_q <= mem_d;
    end
endmodule
`default_nettype wire

// File: tb/tb_exp_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_exp_lut_pipe
// Purpose : Self-checking bench for exp_lut_pipe with table SRAM models and
//           an arithmetic reference of the lookup/multiply/override rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_exp_lut_pipe;
    localparam int E_MIN = -7, E_MAX = 6, E_BITS = 4, HI_BITS = 11;
    localparam int SRAM_LAT = 1, MUL_LAT = 2, FIFO_DEPTH = 8;
    localparam int LO_BITS  = 23 - HI_BITS;
    localparam int HI_IDX_W = E_BITS + HI_BITS + 1;
    localparam int LO_IDX_W = E_BITS + LO_BITS + 1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] acc_q[$];
    logic [31:0] out_q[$];

    always #5 clk = ~clk;

    exp_lut_pipe_if #(.E_BITS(E_BITS), .HI_BITS(HI_BITS)) bus ();

    exp_lut_pipe #(
        .E_MIN(E_MIN), .E_MAX(E_MAX), .E_BITS(E_BITS), .HI_BITS(HI_BITS),
        .SRAM_LAT(SRAM_LAT), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] tab_hi(input logic [HI_IDX_W-1:0] idx);
        logic [31:0] h;
        if (idx == 16'h7000) return 32'h402DF854;
        h = {16'd0, idx} * 32'h9E3779B1 + 32'h01234567;
        return {h[31], 8'd118 + {4'd0, h[7:4]}, h[30:8]};
    endfunction

    function automatic logic [31:0] tab_lo(input logic [LO_IDX_W-1:0] idx);
        logic [31:0] h;
        if (idx == 17'h0E000) return 32'h3F800000;
        h = {15'd0, idx} * 32'h85EBCA6B + 32'h00009E37;
        return {h[31] ^ h[0], 8'd118 + {4'd0, h[11:8]}, h[30:8]};
    endfunction

    // Product of two normal FP32 values, round to nearest even, by integer arithmetic.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, p, q, rem, half;
        int e, sh;
        logic [7:0] eo;
        ma = 64'h800000 + {41'd0, a[22:0]};
        mb = 64'h800000 + {41'd0, b[22:0]};
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
        else sh = 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
        eo = 8'(e);
        return {a[31] ^ b[31], eo, q[22:0]};
    endfunction

    function automatic logic [31:0] ref_exp(input logic [31:0] x);
        int e;
        logic [E_BITS-1:0]   eadj;
        logic [HI_IDX_W-1:0] hi_idx;
        logic [LO_IDX_W-1:0] lo_idx;
        e = int'(x[30:23]);
        if (e == 255 && x[22:0] != 0) return 32'h7FC00000;
        if (e == 255 || e >= 127 + E_MAX) return x[31] ? 32'h0 : 32'h7F800000;
        if (e < 127 + E_MIN) return 32'h3F800000;
        eadj   = E_BITS'(e - (127 + E_MIN));
        hi_idx = {eadj, x[22:LO_BITS], x[31]};
        lo_idx = {eadj, x[LO_BITS-1:0], x[31]};
        return ref_mul(tab_hi(hi_idx), tab_lo(lo_idx));
    endfunction

    function automatic logic [31:0] rnd_in();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom();
        e = 8'(120 + $urandom_range(0, 12));
        return {r[31], e, r[22:0]};
    endfunction

    // Table SRAM models (one cycle read latency).
    always @(posedge clk) begin
        if (bus.sram_hi_en) bus.sram_hi_data <= tab_hi(bus.sram_hi_idx);
        if (bus.sram_lo_en) bus.sram_lo_data <= tab_lo(bus.sram_lo_idx);
    end

    // Handshake monitor: records accepted operands and popped results.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready)  acc_q.push_back(bus.in_x);
            if (bus.out_valid && bus.out_ready) out_q.push_back(bus.out_y);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives vals with random valid/ready until all accepted, then drains
    // until out_q holds out_target entries plus a few spare cycles.
    task automatic feed(input logic [31:0] vals[$], input int vpct, input int rpct,
                        input int out_target, output bit ok);
        int base_a = acc_q.size();
        int n = vals.size();
        int cyc = 0;
        while (acc_q.size() - base_a < n && cyc < 5000) begin
            bus.in_valid  = ($urandom_range(0, 99) < vpct);
            bus.in_x      = vals[acc_q.size() - base_a];
            bus.out_ready = ($urandom_range(0, 99) < rpct);
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (out_q.size() < out_target && cyc < 5000) begin
            tick();
            cyc++;
        end
        repeat (6) tick();
        ok = (cyc < 5000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_x      = 32'h3F800000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.sram_hi_en !== 1'b0) begin errors++; $display("FAIL rst_hi_en got=%b exp=0", bus.sram_hi_en); end
        checks++; if (bus.sram_lo_en !== 1'b0) begin errors++; $display("FAIL rst_lo_en got=%b exp=0", bus.sram_lo_en); end
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid got=%b exp=0", bus.out_valid); end
        tick();
    endtask

    task automatic test_basic();
        int lat;
        bus.in_valid  = 1'b1;
        bus.in_x      = 32'h3F800000;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.sram_hi_en !== 1'b1) begin errors++; $display("FAIL basic_hi_en got=%b exp=1", bus.sram_hi_en); end
        checks++; if (bus.sram_lo_en !== 1'b1) begin errors++; $display("FAIL basic_lo_en got=%b exp=1", bus.sram_lo_en); end
        checks++; if (bus.sram_hi_idx !== 16'h7000) begin errors++; $display("FAIL basic_hi_idx got=%h exp=7000", bus.sram_hi_idx); end
        checks++; if (bus.sram_lo_idx !== 17'h0E000) begin errors++; $display("FAIL basic_lo_idx got=%h exp=0e000", bus.sram_lo_idx); end
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        checks++; if (bus.sram_hi_en !== 1'b0) begin errors++; $display("FAIL basic_en_drop got=%b exp=0", bus.sram_hi_en); end
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        checks++; if (bus.out_y !== 32'h402DF854) begin errors++; $display("FAIL basic_out_y got=%h exp=402df854", bus.out_y); end
        tick();
        repeat (3) tick();
    endtask

    task automatic test_specials();
        logic [31:0] vals[$] = '{32'h00000000, 32'h7F800000, 32'hFF800000,
                                 32'h7FC00001, 32'h42800000, 32'hC2800000};
        logic [31:0] expv[$] = '{32'h3F800000, 32'h7F800000, 32'h00000000,
                                 32'h7FC00000, 32'h7F800000, 32'h00000000};
        bit ok;
        acc_q.delete(); out_q.delete();
        feed(vals, 100, 100, 6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL specials_timeout got=timeout exp=done"); end
        checks++; if (out_q.size() != 6) begin errors++; $display("FAIL specials_count got=%0d exp=6", out_q.size()); end
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== expv[i]) begin errors++; $display("FAIL special_%0d got=%h exp=%h", i, out_q[i], expv[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] vals[$];
        logic [31:0] rest[$];
        bit ok;
        acc_q.delete(); out_q.delete();
        for (int i = 0; i < 20; i++) vals.push_back(rnd_in());
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_x = vals[acc_q.size()];
            tick();
        end
        @(negedge clk);
        checks++; if (acc_q.size() != FIFO_DEPTH) begin errors++; $display("FAIL bp_accepts got=%0d exp=%0d", acc_q.size(), FIFO_DEPTH); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
        for (int i = acc_q.size(); i < 20; i++) rest.push_back(vals[i]);
        tick();
        feed(rest, 100, 100, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=timeout exp=done"); end
        checks++; if (out_q.size() != 20) begin errors++; $display("FAIL bp_count got=%0d exp=20", out_q.size()); end
        for (int i = 0; i < 20 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== ref_exp(vals[i])) begin errors++; $display("FAIL bp_data_%0d got=%h exp=%h", i, out_q[i], ref_exp(vals[i])); end
        end
    endtask

    task automatic test_stream();
        logic [31:0] vals[$];
        int cyc = 0;
        int drops = 0;
        acc_q.delete(); out_q.delete();
        for (int i = 0; i < 100; i++) vals.push_back(rnd_in());
        bus.out_ready = 1'b1;
        while (acc_q.size() < 100 && cyc < 400) begin
            bus.in_valid = 1'b1;
            bus.in_x     = vals[acc_q.size()];
            @(negedge clk);
            if (bus.in_ready !== 1'b1) drops++;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++; if (drops != 0) begin errors++; $display("FAIL stream_in_ready_drops got=%0d exp=0", drops); end
        checks++; if (cyc != 100) begin errors++; $display("FAIL stream_cycles got=%0d exp=100", cyc); end
        repeat (10) tick();
        checks++; if (out_q.size() != 100) begin errors++; $display("FAIL stream_count got=%0d exp=100", out_q.size()); end
        for (int i = 0; i < 100 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== ref_exp(vals[i])) begin errors++; $display("FAIL stream_data_%0d got=%h exp=%h", i, out_q[i], ref_exp(vals[i])); end
        end
    endtask

    task automatic test_random_ready();
        logic [31:0] va[$];
        logic [31:0] vb[$];
        logic [31:0] all[$];
        bit ok_a, ok_b;
        acc_q.delete(); out_q.delete();
        for (int i = 0; i < 150; i++) begin va.push_back(rnd_in()); all.push_back(va[i]); end
        for (int i = 0; i < 150; i++) begin vb.push_back(rnd_in()); all.push_back(vb[i]); end
        feed(va, 90, 30, 0, ok_a);
        feed(vb, 40, 90, 300, ok_b);
        checks++; if (!(ok_a && ok_b)) begin errors++; $display("FAIL rr_timeout got=timeout exp=done"); end
        checks++; if (out_q.size() != 300) begin errors++; $display("FAIL rr_count got=%0d exp=300", out_q.size()); end
        for (int i = 0; i < 300 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== ref_exp(all[i])) begin errors++; $display("FAIL rr_data_%0d got=%h exp=%h", i, out_q[i], ref_exp(all[i])); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] one[$];
        bit ok;
        acc_q.delete(); out_q.delete();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            bus.in_x = rnd_in();
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (acc_q.size() != FIFO_DEPTH) begin errors++; $display("FAIL mid_accepts got=%0d exp=%0d", acc_q.size(), FIFO_DEPTH); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_post_in_ready got=%b exp=1", bus.in_ready); end
        bus.out_ready = 1'b1;
        repeat (20) tick();
        checks++; if (out_q.size() != 0) begin errors++; $display("FAIL mid_stale_results got=%0d exp=0", out_q.size()); end
        acc_q.delete(); out_q.delete();
        one.push_back(rnd_in());
        feed(one, 100, 100, 1, ok);
        checks++; if (!ok || out_q.size() != 1) begin errors++; $display("FAIL mid_fresh_count got=%0d exp=1", out_q.size()); end
        if (out_q.size() > 0) begin
            checks++;
            if (out_q[0] !== ref_exp(one[0])) begin errors++; $display("FAIL mid_fresh_data got=%h exp=%h", out_q[0], ref_exp(one[0])); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = 32'd0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_basic();
        test_specials();
        test_backpressure();
        test_stream();
        test_random_ready();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/exp_lut_pipe.md
Name: exp_lut_pipe

Overview:
- Pipelined, parametrised FP32 exp(x) unit.
- Splits the mantissa into hi/lo fields and looks up two external SRAM tables indexed by {exponent offset, mantissa part, sign}.
- Multiplies the two table words in the team FP32 multiplier FP_MUL_FP32 (ports clk, rst, inA, inB, out; latency MUL_LAT).
- Adds valid/ready handshaking, IEEE special-case handling, SRAM read enables, and a credit-protected output FIFO. Sits between the vector datapath and the activation writeback.

Parameters:
E_MIN, -7, smallest unbiased exponent served by the tables; smaller exponents return 1.0
E_MAX, 6, unbiased exponent at and above which the result saturates
E_BITS, 4, width of exponent offset field; requires E_MAX-E_MIN < 2^E_BITS
HI_BITS, 11, mantissa bits in hi index (M[22:23-HI_BITS]); LO_BITS = 23-HI_BITS
SRAM_LAT, 1, cycles from sram_*_en to valid sram_*_data (>=1)
MUL_LAT, 2, FP_MUL_FP32 pipeline latency (>=1)
FIFO_DEPTH, 8, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  unit can accept
in_x  in  32  FP32 operand
out_valid  out  1  result available (FIFO head)
out_ready  in  1  consumer accepts
out_y  out  32  FP32 result
sram_hi_en  out  1  hi table read enable
sram_hi_idx  out  E_BITS+HI_BITS+1  {E_adj, M_hi, S}
sram_hi_data  in  32  hi table word
sram_lo_en  out  1  lo table read enable
sram_lo_idx  out  E_BITS+LO_BITS+1  {E_adj, M_lo, S}
sram_lo_data  in  32  lo table word

Behaviour:
- Accept when in_valid & in_ready (cycle t). The SRAM enables equal the accept signal. Indices are combinational from in_x.
- E_adj = (E - (127+E_MIN)) truncated to E_BITS. M_hi = M[22:LO_BITS]. M_lo = M[LO_BITS-1:0].
- Enables are low when not accepting; idx then don't-care.
- SRAM data is sampled at t+SRAM_LAT and fed to multiplier inA=hi, inB=lo.
- Product appears at t+SRAM_LAT+MUL_LAT and is written to the FIFO at that edge. out_valid is earliest in cycle t+LAT, LAT = SRAM_LAT+MUL_LAT+1.
- A class code (NORM, ONE, PINF, ZERO, QNAN) and a valid bit travel in a shift register of depth SRAM_LAT+MUL_LAT alongside the data. The override is applied at FIFO write:
  - E==255, M!=0: 0x7FC00000 (checked first)
  - E==255, M==0: S=0 gives 0x7F800000; S=1 gives 0x00000000
  - E >= 127+E_MAX: S=0 gives 0x7F800000; S=1 gives 0x00000000
  - E < 127+E_MIN (includes zero/denormal): 0x3F800000
  - otherwise: multiplier output
- SRAM is still read for override classes; the data is ignored.
- Credits: in_ready = !rst_q & (fifo_count + inflight < FIFO_DEPTH), where inflight is the number of set valid bits in the shift register. The FIFO never overflows and results are never dropped.
- FIFO: out_valid = count!=0; out_y = head entry (registered storage). A pop on out_valid & out_ready. Same-cycle push and pop is legal, including at full or empty.
- in_ready is registered/derived from the current count, so a pop in cycle n frees credit no earlier than cycle n+1.
- Order is strictly preserved.
- Reset: synchronous; in-flight valid bits cleared, FIFO emptied, pointers at 0.
  - During the rst cycle: out_valid=0, in_ready=0, sram_*_en=0.
  - in_ready=1 the cycle after rst deasserts.
  - Reset mid-stream discards all in-flight and queued results.
- Throughput: one result per cycle when out_ready is held high.

Test Plan:
- x=0x3F800000 (1.0); bench SRAM model returns hi=0x402DF854 when sram_hi_idx=0x7000 and lo=0x3F800000 when sram_lo_idx=0xE000 -> both enables pulse at accept; out_y=0x402DF854 with out_valid first high LAT=4 cycles after accept.
- Specials: 0x00000000 -> 0x3F800000; 0x7F800000 -> 0x7F800000; 0xFF800000 -> 0x00000000; 0x7FC00001 -> 0x7FC00000; 0x42800000 (64.0) -> 0x7F800000; 0xC2800000 -> 0x00000000.
- Backpressure: out_ready=0, in_valid=1 for 20 cycles -> exactly 8 accepts, then in_ready=0. Raise out_ready -> all 20 results emerge in input order, none lost.
- Streaming: 100 random in-range inputs, out_ready=1 -> one accept per cycle, no in_ready drop after fill, outputs match reference model bit-exact.
- Random out_ready toggling with same-cycle push/pop at count=FIFO_DEPTH and count=0 -> no overflow, no duplicate, order preserved.
- Assert rst with 3 in flight and 5 queued -> next cycle out_valid=0, in_ready=1, and no stale result appears later.
